tt_mask_idx_elem_gen: RTL and testbench
=======================================

// Module: tt_mask_idx_elem_gen
// PURPOSE
//  Downstream consumer of the mask/index item stream for vector memops. Buffers 65-bit
//  {mask,idx/maskword} items in a credit-managed FIFO and returns one credit per pop.
//  Expands items into per-element requests {addr, active, idx, last} for the LSU
//  element pipe. Covers unit/strided (masked or unmasked) and indexed (masked or unmasked).
// PARAMETERS
//  VLEN          256  vector length in bits; max elements per memop = VLEN
//  MASK_CREDITS  2    FIFO depth; equals upstream initial credit count
// PORTS
//  i_clk               in   1                   clock
//  i_reset_n           in   1                   reset
//  i_start             in   1                   memop start pulse; samples i_base..i_vl
//  i_base              in   64                  base byte address
//  i_stride            in   64                  signed byte stride (unit-stride: stride=EEW bytes)
//  i_is_indexed        in   1                   indexed memop
//  i_is_masked         in   1                   masked memop
//  i_vl                in   $clog2(VLEN+1)      element count
//  i_mask_idx_valid    in   1                   item push
//  i_mask_idx_item     in   65                  [64]=mask bit (indexed), [63:0]=index or mask word
//  i_mask_idx_last_idx in   1                   last item of memop
//  o_mask_idx_credit   out  1                   one-cycle credit return, one per pop
//  o_elem_valid        out  1                   element request valid
//  i_elem_ready        in   1                   element request accepted
//  o_elem_addr         out  64                  element byte address
//  o_elem_active       out  1                   element enabled (mask-on)
//  o_elem_idx          out  $clog2(VLEN)        element number 0..vl-1
//  o_elem_last         out  1                   element idx == vl-1
//  o_busy              out  1                   state == RUN
//  o_done              out  1                   one-cycle pulse on memop completion
//  o_err_overflow      out  1                   sticky: push while FIFO full
// BEHAVIOUR
//  Reset i_reset_n, synchronous, active-low; clock i_clk. On reset: all outputs 0, FIFO
//   empty, state IDLE, no credits returned for flushed entries (upstream resets too).
//  FIFO: push on i_mask_idx_valid; entry visible at head next cycle. Push+pop same cycle
//   legal when full. Push while full: drop item, set o_err_overflow until reset.
//  FSM IDLE: i_start with i_vl==0 -> o_done pulse next cycle, stay IDLE. i_start with vl>0
//   -> latch config, addr=i_base, elem=0, bit_ptr=0, go RUN. i_start in RUN ignored.
//  RUN, element source per mode (need_item = indexed or masked):
//   - unmasked non-indexed: no FIFO use; valid=1, active=1, addr=base+elem*stride.
//   - masked non-indexed: head word; active=word[bit_ptr]; addr=base+elem*stride;
//     pop when bit_ptr==63 or last element accepted; bit_ptr wraps 63->0.
//   - indexed: addr=base+item[63:0]; active = is_masked ? item[64] : 1; pop each element.
//   need_item modes: o_elem_valid = RUN && FIFO non-empty.
//  Handshake: element retires on o_elem_valid && i_elem_ready; outputs held stable while
//   valid && !ready. Strided addr accumulator += stride per retire (mod 2^64, signed).
//  o_elem_valid/addr/active/idx/last driven from registered state and FIFO head only; no
//   combinational path from i_mask_idx_* or i_start.
//  Last element retire: RUN->IDLE, o_done pulse next cycle; mask-word bits above vl
//   dropped with the pop. Items left in FIFO at done are not expected; if present,
//   they stay queued.
//  o_mask_idx_credit: registered, asserted cycle after each pop.
//  i_mask_idx_last_idx informational only; completion is by element count.
// TESTING
//  1 unmasked strided: base=0x1000, stride=8, vl=4, ready=1 -> addr 1000,1008,1010,1018,
//    active=1, last on idx3, o_done next cycle, zero credits.
//  2 masked unit, vl=70: words 0x5, 0x2 -> 70 elems, active on idx 0,2,65 only,
//    2 credits total, 1st credit cycle after idx63 retires.
//  3 indexed masked, vl=3, base=0x100, items {1,0x10},{0,0x20},{1,-8} ->
//    addr 110/120/F8, active 1/0/1, 3 credits.
//  4 backpressure: ready low 5 cycles mid-op -> outputs stable, no pop/credit,
//    resume in order.
//  5 vl=0 start -> o_done next cycle, never busy; push 3 items with depth 2, no pops ->
//    o_err_overflow=1.
//  6 reset asserted mid-RUN with 2 queued items -> IDLE, FIFO empty, no credit pulses,
//    new start runs clean.

Source files
------------

// File: rtl/tt_mask_idx_elem_gen.sv
// Mask/index item consumer for vector memops: buffers items in a credit-managed FIFO
// and expands each memop into per-element {addr, active, idx, last} requests.
module tt_mask_idx_elem_gen #(
    parameter int VLEN         = 256,
    parameter int MASK_CREDITS = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_start,
    input  logic [63:0]                i_base,
    input  logic [63:0]                i_stride,
    input  logic                       i_is_indexed,
    input  logic                       i_is_masked,
    input  logic [$clog2(VLEN+1)-1:0]  i_vl,
    input  logic                       i_mask_idx_valid,
    input  logic [64:0]                i_mask_idx_item,
    input  logic                       i_mask_idx_last_idx,
    output logic                       o_mask_idx_credit,
    output logic                       o_elem_valid,
    input  logic                       i_elem_ready,
    output logic [63:0]                o_elem_addr,
    output logic                       o_elem_active,
    output logic [$clog2(VLEN)-1:0]    o_elem_idx,
    output logic                       o_elem_last,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err_overflow
);

    localparam int VLW = $clog2(VLEN + 1);
    localparam int IW  = $clog2(VLEN);
    localparam int PW  = (MASK_CREDITS > 1) ? $clog2(MASK_CREDITS) : 1;
    localparam int CW  = $clog2(MASK_CREDITS + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [64:0]    fifo_mem [MASK_CREDITS];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           fifo_empty, fifo_full, push_ok, pop;
    logic [64:0]    head;
    logic [63:0]    head_word;

    logic [63:0]    addr_r, stride_r;
    logic           is_indexed_r, is_masked_r;
    logic [VLW-1:0] vl_r;
    logic [IW-1:0]  elem_r;
    logic [5:0]     bit_ptr;
    logic           done_r, credit_r, overflow_r;
    logic           run, need_item, retire, last_elem;
    logic           unused_last_idx;

    // Completion is counted in elements, so the upstream last-item flag carries no state here.
    assign unused_last_idx = i_mask_idx_last_idx;

    assign run        = (state == RUN);
    assign need_item  = is_indexed_r || is_masked_r;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(MASK_CREDITS));
    assign head       = fifo_mem[rd_ptr];
    assign head_word  = head[63:0];
    assign last_elem  = (VLW'(elem_r) == vl_r - VLW'(1));

    assign o_elem_valid  = run && (!need_item || !fifo_empty);
    assign o_elem_addr   = !run ? '0 : (is_indexed_r ? addr_r + head_word : addr_r);
    assign o_elem_active = run && (is_indexed_r ? (!is_masked_r || head[64])
                                                : (!is_masked_r || head_word[bit_ptr]));
    assign o_elem_idx    = run ? elem_r : '0;
    assign o_elem_last   = run && last_elem;
    assign o_busy        = run;
    assign o_done        = done_r;
    assign o_mask_idx_credit = credit_r;
    assign o_err_overflow    = overflow_r;

    assign retire = o_elem_valid && i_elem_ready;
    // A mask word is released after its 64th bit or with the final element, whichever comes first.
    assign pop    = retire && (is_indexed_r ||
                               (is_masked_r && ((bit_ptr == 6'd63) || last_elem)));
    assign push_ok = i_mask_idx_valid && (!fifo_full || pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start && (i_vl != '0)) state_next = RUN;
            RUN:     if (retire && last_elem) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= i_mask_idx_item;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
            credit_r   <= 1'b0;
        end else begin
            credit_r <= pop;
            count    <= count + CW'(push_ok) - CW'(pop);
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PW'(MASK_CREDITS - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(MASK_CREDITS - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (i_mask_idx_valid && !push_ok) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Indexed mode keeps addr_r at the base; strided modes walk it by one stride per retire.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            addr_r       <= '0;
            stride_r     <= '0;
            is_indexed_r <= 1'b0;
            is_masked_r  <= 1'b0;
            vl_r         <= '0;
            elem_r       <= '0;
            bit_ptr      <= '0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!run && i_start) begin
                if (i_vl == '0) begin
                    done_r <= 1'b1;
                end else begin
                    addr_r       <= i_base;
                    stride_r     <= i_stride;
                    is_indexed_r <= i_is_indexed;
                    is_masked_r  <= i_is_masked;
                    vl_r         <= i_vl;
                    elem_r       <= '0;
                    bit_ptr      <= '0;
                end
            end else if (retire) begin
                elem_r  <= elem_r + 1'b1;
                bit_ptr <= bit_ptr + 1'b1;
                if (!is_indexed_r) begin
                    addr_r <= addr_r + stride_r;
                end
                if (last_elem) begin
                    done_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_mask_idx_elem_gen.sv
// Self-checking bench for tt_mask_idx_elem_gen: directed vector table, hand-written
// corner sequences, and randomized memops checked against a spec-level model.
module tb_tt_mask_idx_elem_gen;

    localparam int VLEN         = 256;
    localparam int MASK_CREDITS = 2;
    localparam int VLW          = $clog2(VLEN + 1);
    localparam int IW           = $clog2(VLEN);

    logic           i_clk = 1'b0;
    logic           i_reset_n;
    logic           i_start;
    logic [63:0]    i_base;
    logic [63:0]    i_stride;
    logic           i_is_indexed;
    logic           i_is_masked;
    logic [VLW-1:0] i_vl;
    logic           i_mask_idx_valid;
    logic [64:0]    i_mask_idx_item;
    logic           i_mask_idx_last_idx;
    logic           o_mask_idx_credit;
    logic           o_elem_valid;
    logic           i_elem_ready;
    logic [63:0]    o_elem_addr;
    logic           o_elem_active;
    logic [IW-1:0]  o_elem_idx;
    logic           o_elem_last;
    logic           o_busy;
    logic           o_done;
    logic           o_err_overflow;

    int checks = 0;
    int errors = 0;
    logic [64:0] item_q[$];

    typedef struct packed {
        logic [63:0]      base;
        logic [63:0]      stride;
        logic             indexed;
        logic             masked;
        int               vl;
        int               n_items;
        logic [2:0][64:0] items;
        int               exp_active;
        int               exp_credits;
        logic [63:0]      exp_last_addr;
    } vec_t;

    vec_t vecs[6];

    tt_mask_idx_elem_gen #(
        .VLEN         (VLEN),
        .MASK_CREDITS (MASK_CREDITS)
    ) dut (
        .i_clk               (i_clk),
        .i_reset_n           (i_reset_n),
        .i_start             (i_start),
        .i_base              (i_base),
        .i_stride            (i_stride),
        .i_is_indexed        (i_is_indexed),
        .i_is_masked         (i_is_masked),
        .i_vl                (i_vl),
        .i_mask_idx_valid    (i_mask_idx_valid),
        .i_mask_idx_item     (i_mask_idx_item),
        .i_mask_idx_last_idx (i_mask_idx_last_idx),
        .o_mask_idx_credit   (o_mask_idx_credit),
        .o_elem_valid        (o_elem_valid),
        .i_elem_ready        (i_elem_ready),
        .o_elem_addr         (o_elem_addr),
        .o_elem_active       (o_elem_active),
        .o_elem_idx          (o_elem_idx),
        .o_elem_last         (o_elem_last),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_err_overflow      (o_err_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic vec_t make_vec(input logic [63:0] base, input logic [63:0] stride,
                                      input logic indexed, input logic masked, input int vl,
                                      input logic [64:0] i0, input logic [64:0] i1,
                                      input logic [64:0] i2, input int n_items,
                                      input int exp_active, input int exp_credits,
                                      input logic [63:0] exp_last_addr);
        vec_t v;
        v.base = base;
        v.stride = stride;
        v.indexed = indexed;
        v.masked = masked;
        v.vl = vl;
        v.items[0] = i0;
        v.items[1] = i1;
        v.items[2] = i2;
        v.n_items = n_items;
        v.exp_active = exp_active;
        v.exp_credits = exp_credits;
        v.exp_last_addr = exp_last_addr;
        return v;
    endfunction

    task automatic resetDut();
        i_reset_n = 1'b0;
        i_start = 1'b0;
        i_base = '0;
        i_stride = '0;
        i_is_indexed = 1'b0;
        i_is_masked = 1'b0;
        i_vl = '0;
        i_mask_idx_valid = 1'b0;
        i_mask_idx_item = '0;
        i_mask_idx_last_idx = 1'b0;
        i_elem_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_valid", 64'(o_elem_valid), 64'd0);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_done", 64'(o_done), 64'd0);
        checkOutput("rst_credit", 64'(o_mask_idx_credit), 64'd0);
        checkOutput("rst_overflow", 64'(o_err_overflow), 64'd0);
        checkOutput("rst_addr", o_elem_addr, 64'd0);
        checkOutput("rst_attr", 64'({o_elem_active, o_elem_last, o_elem_idx}), 64'd0);
        i_reset_n = 1'b1;
        @(negedge i_clk);
    endtask

    // Runs one memop from IDLE, feeding item_q under credit control and checking every
    // element, credit and done pulse against a model built from the memop rules.
    task automatic applyStimulus(input logic [63:0] base, input logic [63:0] stride,
                                 input logic indexed, input logic masked, input int vl,
                                 input int stall_start, input bit rand_ready,
                                 output int active_cnt, output int credit_cnt,
                                 output logic [63:0] last_addr);
        logic [63:0]   exp_addr[$];
        logic          exp_act[$];
        logic          exp_pop[$];
        logic [63:0]   word;
        logic [64:0]   it;
        logic [63:0]   h_addr;
        logic [IW+1:0] h_attr;
        int            e, push_idx, cred_avail, budget;
        logic          cred_exp, done_exp, held, ready, finished;

        for (int k = 0; k < vl; k++) begin
            if (indexed) begin
                it = item_q[k];
                exp_addr.push_back(base + it[63:0]);
                exp_act.push_back(masked ? it[64] : 1'b1);
                exp_pop.push_back(1'b1);
            end else begin
                exp_addr.push_back(base + stride * 64'(k));
                if (masked) begin
                    it = item_q[k / 64];
                    word = it[63:0];
                end else begin
                    word = '1;
                end
                exp_act.push_back(word[k % 64]);
                exp_pop.push_back(masked && ((k % 64 == 63) || (k == vl - 1)));
            end
        end

        e = 0;
        push_idx = 0;
        cred_avail = MASK_CREDITS;
        budget = 4 * vl + 100;
        cred_exp = 1'b0;
        done_exp = 1'b0;
        held = 1'b0;
        finished = 1'b0;
        h_addr = '0;
        h_attr = '0;
        active_cnt = 0;
        credit_cnt = 0;
        last_addr = '0;

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) begin
                checkOutput("credit", 64'(o_mask_idx_credit), 64'(cred_exp));
                checkOutput("done", 64'(o_done), 64'(done_exp));
                if (o_mask_idx_credit) begin
                    cred_avail++;
                    credit_cnt++;
                end
                if (done_exp) begin
                    checkOutput("busy_after_done", 64'(o_busy), 64'd0);
                    finished = 1'b1;
                    break;
                end
            end
            cred_exp = 1'b0;
            done_exp = 1'b0;
            if (cyc == 0) begin
                i_start = 1'b1;
                i_base = base;
                i_stride = stride;
                i_is_indexed = indexed;
                i_is_masked = masked;
                i_vl = VLW'(vl);
                done_exp = (vl == 0);
            end else begin
                i_start = 1'b0;
            end
            if (held) begin
                checkOutput("hold_valid", 64'(o_elem_valid), 64'd1);
                checkOutput("hold_addr", o_elem_addr, h_addr);
                checkOutput("hold_attr", 64'({o_elem_active, o_elem_last, o_elem_idx}),
                            64'(h_attr));
            end
            if (stall_start >= 0) begin
                ready = !(cyc >= stall_start && cyc < stall_start + 5);
            end else if (rand_ready) begin
                ready = ($urandom_range(0, 3) != 0);
            end else begin
                ready = 1'b1;
            end
            i_elem_ready = ready;
            if (o_elem_valid && ready) begin
                if (e >= vl) begin
                    checkOutput("extra_elem", 64'(o_elem_valid), 64'd0);
                end else begin
                    checkOutput("addr", o_elem_addr, exp_addr[e]);
                    checkOutput("active", 64'(o_elem_active), 64'(exp_act[e]));
                    checkOutput("idx", 64'(o_elem_idx), 64'(e));
                    checkOutput("last", 64'(o_elem_last), 64'(e == vl - 1));
                    active_cnt += int'(o_elem_active);
                    last_addr = o_elem_addr;
                    cred_exp = exp_pop[e];
                    done_exp = (e == vl - 1);
                    e++;
                end
            end
            held = o_elem_valid && !ready;
            h_addr = o_elem_addr;
            h_attr = {o_elem_active, o_elem_last, o_elem_idx};
            if (push_idx < item_q.size() && cred_avail > 0) begin
                i_mask_idx_valid = 1'b1;
                i_mask_idx_item = item_q[push_idx];
                i_mask_idx_last_idx = (push_idx == item_q.size() - 1);
                push_idx++;
                cred_avail--;
            end else begin
                i_mask_idx_valid = 1'b0;
                i_mask_idx_item = '0;
                i_mask_idx_last_idx = 1'b0;
            end
            @(negedge i_clk);
        end
        i_start = 1'b0;
        i_mask_idx_valid = 1'b0;
        i_mask_idx_last_idx = 1'b0;
        i_elem_ready = 1'b1;
        if (!finished) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout elements=%0d required=%0d", e, vl);
        end
        checkOutput("no_overflow", 64'(o_err_overflow), 64'd0);
    endtask

    task automatic runVec(input vec_t v, input int stall_start, input bit rand_ready);
        int ac, cc;
        logic [63:0] la;
        item_q.delete();
        for (int j = 0; j < v.n_items; j++) item_q.push_back(v.items[j]);
        applyStimulus(v.base, v.stride, v.indexed, v.masked, v.vl, stall_start, rand_ready,
                      ac, cc, la);
        checkOutput("vec_active_count", 64'(ac), 64'(v.exp_active));
        checkOutput("vec_credit_count", 64'(cc), 64'(v.exp_credits));
        checkOutput("vec_last_addr", la, v.exp_last_addr);
    endtask

    initial begin
        int ac, cc, n, vl;
        logic ix, mk;
        logic [63:0] base, stride, la;

        vecs[0] = make_vec(64'h1000, 64'd8, 1'b0, 1'b0, 4, '0, '0, '0, 0, 4, 0, 64'h1018);
        vecs[1] = make_vec(64'h2000, 64'd4, 1'b0, 1'b1, 70, 65'h5, 65'h2, '0, 2, 3, 2,
                           64'h2114);
        vecs[2] = make_vec(64'h100, 64'd0, 1'b1, 1'b1, 3, {1'b1, 64'h10}, {1'b0, 64'h20},
                           {1'b1, 64'hFFFF_FFFF_FFFF_FFF8}, 3, 2, 3, 64'hF8);
        vecs[3] = make_vec(64'h4000, 64'd0, 1'b1, 1'b0, 3, {1'b0, 64'h8}, {1'b1, 64'h0},
                           {1'b0, 64'h30}, 3, 3, 3, 64'h4030);
        vecs[4] = make_vec(64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b0, 5, '0, '0, '0, 0,
                           5, 0, 64'hC0);
        vecs[5] = make_vec(64'h0, 64'd1, 1'b0, 1'b1, 64, 65'h8000_0000_0000_0001, '0, '0,
                           1, 2, 1, 64'h3F);

        resetDut();

        for (int i = 0; i < 6; i++) runVec(vecs[i], -1, 1'b0);

        $display("[TB] backpressure sequences");
        runVec(vecs[1], 10, 1'b0);
        runVec(vecs[3], 2, 1'b0);

        $display("[TB] vl=0 start and overflow");
        i_start = 1'b1;
        i_vl = '0;
        @(negedge i_clk);
        i_start = 1'b0;
        checkOutput("vl0_done", 64'(o_done), 64'd1);
        checkOutput("vl0_busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        checkOutput("vl0_done_pulse", 64'(o_done), 64'd0);
        checkOutput("vl0_busy_after", 64'(o_busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            i_mask_idx_valid = 1'b1;
            i_mask_idx_item = 65'(k);
            @(negedge i_clk);
            checkOutput("ovf_push", 64'(o_err_overflow), 64'(k == 2));
        end
        i_mask_idx_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        checkOutput("ovf_sticky", 64'(o_err_overflow), 64'd1);
        checkOutput("ovf_no_credit", 64'(o_mask_idx_credit), 64'd0);

        resetDut();

        $display("[TB] reset mid-run");
        i_elem_ready = 1'b0;
        i_start = 1'b1;
        i_base = 64'h0;
        i_stride = 64'h0;
        i_is_indexed = 1'b1;
        i_is_masked = 1'b1;
        i_vl = VLW'(4);
        i_mask_idx_valid = 1'b1;
        i_mask_idx_item = {1'b1, 64'hAA00};
        @(negedge i_clk);
        i_start = 1'b0;
        i_mask_idx_item = {1'b0, 64'hBB00};
        @(negedge i_clk);
        i_mask_idx_valid = 1'b0;
        @(negedge i_clk);
        checkOutput("midrun_busy", 64'(o_busy), 64'd1);
        checkOutput("midrun_addr", o_elem_addr, 64'hAA00);
        i_reset_n = 1'b0;
        @(negedge i_clk);
        checkOutput("midrun_rst_busy", 64'(o_busy), 64'd0);
        checkOutput("midrun_rst_valid", 64'(o_elem_valid), 64'd0);
        i_reset_n = 1'b1;
        i_elem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            checkOutput("midrun_no_credit", 64'(o_mask_idx_credit), 64'd0);
        end
        runVec(vecs[2], -1, 1'b0);

        $display("[TB] randomized memops");
        for (int r = 0; r < 25; r++) begin
            ix = 1'($urandom_range(0, 1));
            mk = 1'($urandom_range(0, 1));
            vl = (r == 0) ? VLEN : int'($urandom_range(0, VLEN));
            base = {$urandom, $urandom};
            stride = {$urandom, $urandom};
            n = ix ? vl : (mk ? (vl + 63) / 64 : 0);
            item_q.delete();
            for (int k = 0; k < n; k++) item_q.push_back({1'($urandom), $urandom, $urandom});
            applyStimulus(base, stride, ix, mk, vl, -1, 1'b1, ac, cc, la);
            checkOutput("rand_credits", 64'(cc), 64'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
